// File: rtl/led_blink_driver_pkg.sv
// Shared definitions for the LED blink driver: FSM state encoding, LED polarity helper, default timing.
package led_blink_driver_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ON   = 2'd1;
  localparam state_t ST_OFF  = 2'd2;

  // 0.5 s at a 50 MHz board clock
  localparam int DEFAULT_ON_CYCLES  = 25_000_000;
  localparam int DEFAULT_OFF_CYCLES = 25_000_000;
  localparam int DEFAULT_BLINKS     = 3;

  // Pin level for a given lit/dark request under the chosen LED polarity.
  function automatic logic led_level(input logic active_low, input logic lit);
    return lit ^ active_low;
  endfunction

endpackage

// File: rtl/led_blink_driver_cycle_timer.sv
// Loadable down-counter; expire is high during the last cycle of a loaded interval (count == 1).
module led_blink_driver_cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt;

  // Stops at zero so an idle timer never wraps or re-fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/led_blink_driver.sv
// Turns a one-cycle trigger into BLINK_COUNT timed LED blinks with busy/done status.
// All outputs are registered from the next-state decode, so they track the state register exactly.
module led_blink_driver
  import led_blink_driver_pkg::*;
#(
  parameter int ON_CYCLES      = DEFAULT_ON_CYCLES,
  parameter int OFF_CYCLES     = DEFAULT_OFF_CYCLES,
  parameter int BLINK_COUNT    = DEFAULT_BLINKS,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic iTrig,
  input  logic iAbort,
  output logic oExtLed,
  output logic oBusy,
  output logic oDone
);

  localparam int PHASE_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int PW = $clog2(PHASE_MAX + 1);
  localparam int BW = $clog2(BLINK_COUNT + 1);
  localparam logic [PW-1:0] ON_LOAD  = PW'(ON_CYCLES);
  localparam logic [PW-1:0] OFF_LOAD = PW'(OFF_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_COUNT);

  state_t        state;
  state_t        state_nxt;
  logic [BW-1:0] blink;
  logic [BW-1:0] blink_nxt;
  logic          done_nxt;
  logic          load;
  logic [PW-1:0] load_val;
  logic          expire;

  led_blink_driver_cycle_timer #(.W(PW)) u_timer (
    .clk    (CLK),
    .reset  (RESET),
    .load   (load),
    .value  (load_val),
    .expire (expire)
  );

  // Every state change reloads the timer; returning to IDLE loads 0 to clear it.
  always_comb begin
    state_nxt = state;
    blink_nxt = blink;
    done_nxt  = 1'b0;
    load      = 1'b0;
    load_val  = '0;
    case (state)
      ST_IDLE: begin
        if (iTrig && !iAbort) begin
          state_nxt = ST_ON;
          blink_nxt = BW'(1);
          load      = 1'b1;
          load_val  = ON_LOAD;
        end
      end
      ST_ON: begin
        if (iAbort) begin
          state_nxt = ST_IDLE;
          blink_nxt = '0;
          load      = 1'b1;
        end else if (expire) begin
          load = 1'b1;
          if (blink < BLINK_LAST) begin
            state_nxt = ST_OFF;
            load_val  = OFF_LOAD;
          end else begin
            state_nxt = ST_IDLE;
            blink_nxt = '0;
            done_nxt  = 1'b1;
          end
        end
      end
      ST_OFF: begin
        if (iAbort) begin
          state_nxt = ST_IDLE;
          blink_nxt = '0;
          load      = 1'b1;
        end else if (expire) begin
          state_nxt = ST_ON;
          blink_nxt = blink + 1'b1;
          load      = 1'b1;
          load_val  = ON_LOAD;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        blink_nxt = '0;
        load      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= ST_IDLE;
      blink   <= '0;
      oExtLed <= led_level(LED_ACTIVE_LOW, 1'b0);
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
    end else begin
      state   <= state_nxt;
      blink   <= blink_nxt;
      oExtLed <= led_level(LED_ACTIVE_LOW, state_nxt == ST_ON);
      oBusy   <= (state_nxt != ST_IDLE);
      oDone   <= done_nxt;
    end
  end

endmodule
